gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl: RTL and testbench
===========================================================

GF180MCU_FD_SC_MCU9T5V0__ICGTN_IDLE_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of independent gated-clock channels (1..32).
REQ-002 Parameter IDLE_CYC, default 8, CLKN cycles a channel stays running after its enable drops (0..255).
REQ-003 Parameter CW, default 8, idle-counter width; SHALL satisfy 2**CW > IDLE_CYC.
REQ-004 CLKN  input  1  free-running source clock, negative-active gating style; all registers update on rising CLKN.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 TE  input  1  scan/test enable, common to all channels.
REQ-007 E  input  NCH  per-channel functional clock request.
REQ-008 Q  output  NCH  per-channel gated clock; idles high, pulses low with CLKN when enabled.
REQ-009 ACK  output  NCH  per-channel registered status; 1 = channel clock running (state not OFF).

Function
REQ-010 Per-channel request en[i] SHALL be E[i] OR TE.
REQ-011 Each channel SHALL hold a 3-state FSM {OFF, ON, HOLD} and a CW-bit down-counter cnt[i].
REQ-012 OFF: en[i]=1 at rising CLKN -> ON; otherwise remain OFF, cnt unchanged.
REQ-013 ON: en[i]=1 -> remain ON; en[i]=0 -> HOLD with cnt=IDLE_CYC-1, or directly OFF when IDLE_CYC=0.
REQ-014 HOLD: en[i]=1 -> ON (cnt value irrelevant); en[i]=0 and cnt=0 -> OFF; en[i]=0 and cnt>0 -> cnt decrements by 1.
REQ-015 Request reassertion during HOLD SHALL return to ON without gap in Q pulses.
REQ-016 Gate request g[i] SHALL be (state[i] != OFF) OR TE.
REQ-017 Each channel SHALL contain a glitch-free latch: transparent while CLKN=1, holding while CLKN=0, D=g[i], output IQ[i].
REQ-018 Q[i] SHALL equal CLKN OR NOT IQ[i]; Q[i] SHALL never glitch low while CLKN=1 and SHALL not truncate a low phase.
REQ-019 Latency: E[i] sampled high at rising edge k -> ACK[i]=1 after edge k, first Q[i] low pulse in the CLKN low phase of cycle k.
REQ-020 Shutdown: E[i] sampled low at edge k from ON -> Q[i] pulses in exactly IDLE_CYC further low phases (cycles k..k+IDLE_CYC-1), ACK[i]=0 and Q[i] held high from edge k+IDLE_CYC.
REQ-021 TE=1 SHALL force Q pulses on all channels in the same low phase TE is asserted, independent of state; channels SHALL also advance to ON via REQ-010.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL not interact.
REQ-023 Counter SHALL never wrap: decrement only occurs when cnt>0.
REQ-024 E/TE changes while CLKN=0 SHALL not affect Q until the next CLKN high phase.

Reset
REQ-025 RST=1 SHALL asynchronously force every state to OFF, cnt to 0, ACK to 0, and every latch IQ to 0, making Q all-ones immediately, regardless of CLKN phase.
REQ-026 RST asserted mid-pulse (CLKN=0, Q low) SHALL drive Q high immediately; no pulse SHALL appear while RST=1 unless TE=1 re-enables after RST release.
REQ-027 After RST deassertion, operation SHALL resume at the first rising CLKN with all channels OFF.

Verification
REQ-028 Reset: NCH=4, hold RST=1 for 3 cycles with E=4'hF -> Q=4'hF constant, ACK=0; release -> ACK=4'hF after first edge, Q pulses low that cycle.
REQ-029 Idle timeout: IDLE_CYC=8, E[0] high 5 cycles then low at edge k -> exactly 8 further low pulses on Q[0], ACK[0] falls at edge k+8.
REQ-030 Re-wake: IDLE_CYC=8, E[1] drops, reasserted at HOLD cnt=3 -> continuous Q[1] pulses, state ON, no missing low phase.
REQ-031 IDLE_CYC=0: E[2] drop sampled at edge k -> no Q[2] pulse in cycle k, ACK[2]=0 after edge k.
REQ-032 Test mode: all E=0, TE asserted during CLKN high -> all Q pulse same cycle; TE drop -> each channel pulses IDLE_CYC more cycles then stops.
REQ-033 Async reset mid-low-phase with channels active -> Q=all-ones within same low phase, ACK=0, no glitch on CLKN rising.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl.sv
// Multi-channel negative-style clock gate with idle hold-off.
// Each channel keeps its gated clock running for IDLE_CYC CLKN cycles after
// its request drops, so short request gaps do not stop and restart the clock.
// Q idles high and follows CLKN low while the channel's latch is set.
module gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned IDLE_CYC = 8,
  parameter int unsigned CW       = 8
) (
  input  logic           CLKN,
  input  logic           RST,
  input  logic           TE,
  input  logic [NCH-1:0] E,
  output logic [NCH-1:0] Q,
  output logic [NCH-1:0] ACK
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Counter load on leaving ON; only meaningful when IDLE_CYC > 0.
  localparam logic [CW-1:0] RELOAD = (IDLE_CYC == 0) ? '0 : CW'(IDLE_CYC - 1);

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] gate;
  logic [NCH-1:0] iq;

  // Per-channel request: functional enable or scan/test override.
  always_comb begin
    en = E | {NCH{TE}};
  end

  // State and idle counters, asynchronously cleared.
  always_ff @(posedge CLKN or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state: OFF -> ON on request, ON -> HOLD (or OFF) on release,
  // HOLD counts down to OFF unless the request returns.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_OFF: begin
          if (en[i]) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!en[i]) begin
            if (IDLE_CYC == 0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = RELOAD;
            end
          end
        end
        ST_HOLD: begin
          if (en[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Status and gate request derived from the registered state.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ACK[i]  = (state_q[i] != ST_OFF);
      gate[i] = (state_q[i] != ST_OFF) | TE;
    end
  end

  // Gating latch: open while CLKN is high so the request settles before the
  // low phase, closed while CLKN is low so a low pulse is never cut short.
  always_latch begin
    if (RST) begin
      iq <= '0;
    end else if (CLKN) begin
      iq <= gate;
    end
  end

  // Gated clock: forced high during CLKN high or when the latch is clear.
  always_comb begin
    Q = {NCH{CLKN}} | ~iq;
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl.sv
// Bench for the idle-hold clock gate: two instances (IDLE_CYC=8 and 0)
// share stimulus; the reference tracks, per channel, how many rising edges
// have passed since the request was last sampled high.
module tb_gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl;

  localparam int NCH = 4;
  localparam int BIG = 1000;

  logic           CLKN = 1'b0;
  logic           RST;
  logic           TE;
  logic [NCH-1:0] E;
  logic [NCH-1:0] q8, ack8, q0, ack0;

  int n_cmp = 0;
  int n_err = 0;
  int since [NCH];
  logic [NCH-1:0] low8, low0;

  gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl #(.NCH(NCH), .IDLE_CYC(8), .CW(8)) dut8 (
    .CLKN(CLKN), .RST(RST), .TE(TE), .E(E), .Q(q8), .ACK(ack8)
  );

  gf180mcu_fd_sc_mcu9t5v0__icgtn_idle_ctrl #(.NCH(NCH), .IDLE_CYC(0), .CW(4)) dut0 (
    .CLKN(CLKN), .RST(RST), .TE(TE), .E(E), .Q(q0), .ACK(ack0)
  );

  always #5 CLKN = ~CLKN;

  task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A channel runs after an edge if its request was seen within the last
  // idle edges (inclusive of the current one).
  function automatic logic [NCH-1:0] running(input int idle);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (since[i] <= idle);
    return r;
  endfunction

  // One CLKN cycle: drive in the low phase, sample edge, check high and low phases.
  task automatic step(input logic [NCH-1:0] e, input logic te, input logic r, input logic te_mid);
    logic [NCH-1:0] run8, run0;
    E = e; TE = te; RST = r;
    #1;
    check("hold_q8", q8, r ? '1 : low8);
    check("hold_q0", q0, r ? '1 : low0);
    if (r) begin
      check("rst_ack8", ack8, '0);
      check("rst_ack0", ack0, '0);
    end
    @(posedge CLKN);
    for (int i = 0; i < NCH; i++) begin
      if (RST) since[i] = BIG;
      else if (E[i] | TE) since[i] = 0;
      else if (since[i] < BIG) since[i]++;
    end
    #1;
    run8 = running(8);
    run0 = running(0);
    check("ack8", ack8, run8);
    check("ack0", ack0, run0);
    check("high_q8", q8, '1);
    check("high_q0", q0, '1);
    #1;
    TE = te_mid;
    @(negedge CLKN);
    #1;
    low8 = RST ? '1 : ~(run8 | {NCH{TE}});
    low0 = RST ? '1 : ~(run0 | {NCH{TE}});
    check("low_q8", q8, low8);
    check("low_q0", q0, low0);
    #1;
  endtask

  initial begin
    logic [NCH-1:0] ecur;
    logic           te_r, rst_r;
    RST = 1'b1; TE = 1'b0; E = '1;
    low8 = '1; low0 = '1;
    for (int i = 0; i < NCH; i++) since[i] = BIG;
    #2;

    // Reset held with all requests high, then release.
    repeat (3) step(4'hF, 1'b0, 1'b1, 1'b0);
    repeat (2) step(4'hF, 1'b0, 1'b0, 1'b0);
    repeat (11) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Idle timeout on channel 0.
    repeat (5) step(4'h1, 1'b0, 1'b0, 1'b0);
    repeat (11) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Re-wake on channel 1 while holding (counter at 3).
    repeat (3) step(4'h2, 1'b0, 1'b0, 1'b0);
    repeat (5) step(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'h2, 1'b0, 1'b0, 1'b0);
    repeat (11) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Channel 2 drop (immediate stop on the zero-idle instance).
    repeat (3) step(4'h4, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Test enable raised during the high phase, then dropped.
    step(4'h0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 1'b1, 1'b0, 1'b1);
    repeat (11) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Independent simultaneous transitions on a subset.
    repeat (2) step(4'h5, 1'b0, 1'b0, 1'b0);
    repeat (2) step(4'hA, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Async reset mid low phase with channels active.
    repeat (3) step(4'hF, 1'b0, 1'b0, 1'b0);
    repeat (2) step(4'hF, 1'b0, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b1, 1'b1);
    repeat (2) step(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (10) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with sticky requests.
    ecur = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 5) == 0) ecur[i] = ~ecur[i];
      te_r  = ($urandom_range(0, 19) == 0);
      rst_r = ($urandom_range(0, 79) == 0);
      step(ecur, te_r, rst_r, ($urandom_range(0, 19) == 0) ? ~te_r : te_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
